// File: rtl/ram_arbiter.sv
// Two-port arbiter sharing one single-port RAM between a CPU and a host loader.
// Alternates ownership under contention, capping each run at MAX_RUN accesses.
module ram_arbiter #(
    parameter int MAX_RUN = 4
) (
    input  logic       clk,
    input  logic       rst,
    input  logic       cpu_req,
    input  logic       cpu_we,
    input  logic [7:0] cpu_addr,
    input  logic [7:0] cpu_wdata,
    output logic       cpu_gnt,
    output logic       cpu_ack,
    output logic [7:0] cpu_rdata,
    input  logic       host_req,
    input  logic       host_we,
    input  logic [7:0] host_addr,
    input  logic [7:0] host_wdata,
    output logic       host_gnt,
    output logic       host_ack,
    output logic [7:0] host_rdata,
    output logic [7:0] mem_addr,
    output logic [7:0] mem_wdata,
    output logic       mem_we,
    input  logic [7:0] mem_rdata
);

    typedef enum logic [1:0] {IDLE, CPU_OWN, HOST_OWN} state_t;

    localparam logic [2:0] RUN_MAX = 3'(MAX_RUN);

    state_t     state;
    logic [2:0] run_cnt;
    logic       last_host;

    logic       cpu_acc, host_acc, acc, other_req;
    logic [2:0] run_next;

    // Grants come straight off the state register, so async reset drops them at once.
    assign cpu_gnt   = (state == CPU_OWN);
    assign host_gnt  = (state == HOST_OWN);
    assign cpu_acc   = cpu_gnt & cpu_req;
    assign host_acc  = host_gnt & host_req;
    assign acc       = cpu_acc | host_acc;
    assign other_req = cpu_gnt ? host_req : cpu_req;
    assign run_next  = (run_cnt == RUN_MAX) ? RUN_MAX : run_cnt + 3'd1;

    always_comb begin
        mem_we    = 1'b0;
        mem_addr  = 8'd0;
        mem_wdata = 8'd0;
        if (cpu_acc) begin
            mem_we    = cpu_we;
            mem_addr  = cpu_addr;
            mem_wdata = cpu_wdata;
        end else if (host_acc) begin
            mem_we    = host_we;
            mem_addr  = host_addr;
            mem_wdata = host_wdata;
        end
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state      <= IDLE;
            run_cnt    <= 3'd0;
            last_host  <= 1'b1;
            cpu_ack    <= 1'b0;
            host_ack   <= 1'b0;
            cpu_rdata  <= 8'd0;
            host_rdata <= 8'd0;
        end else begin
            cpu_ack  <= cpu_acc;
            host_ack <= host_acc;
            if (cpu_acc && !cpu_we)
                cpu_rdata <= mem_rdata;
            if (host_acc && !host_we)
                host_rdata <= mem_rdata;

            case (state)
                IDLE: begin
                    run_cnt <= 3'd0;
                    // On a tie the side that did not own the RAM last goes first.
                    if (cpu_req && (!host_req || last_host))
                        state <= CPU_OWN;
                    else if (host_req)
                        state <= HOST_OWN;
                end
                CPU_OWN, HOST_OWN: begin
                    if (!acc || (run_next == RUN_MAX && other_req)) begin
                        state     <= IDLE;
                        run_cnt   <= 3'd0;
                        last_host <= (state == HOST_OWN);
                    end else begin
                        run_cnt <= run_next;
                    end
                end
                default: state <= IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_ram_arbiter.sv
// Bench for ram_arbiter: per-cycle vector table with an ack/read-data scoreboard,
// plus contention, reset-mid-write and RAM content sequences.
module tb_ram_arbiter;

    logic       clk = 1'b0;
    logic       rst;
    logic       cpu_req, cpu_we, host_req, host_we;
    logic [7:0] cpu_addr, cpu_wdata, host_addr, host_wdata;
    logic       cpu_gnt, cpu_ack, host_gnt, host_ack;
    logic [7:0] cpu_rdata, host_rdata;
    logic [7:0] mem_addr, mem_wdata, mem_rdata;
    logic       mem_we;

    ram_arbiter #(.MAX_RUN(4)) dut (
        .clk(clk), .rst(rst),
        .cpu_req(cpu_req), .cpu_we(cpu_we), .cpu_addr(cpu_addr), .cpu_wdata(cpu_wdata),
        .cpu_gnt(cpu_gnt), .cpu_ack(cpu_ack), .cpu_rdata(cpu_rdata),
        .host_req(host_req), .host_we(host_we), .host_addr(host_addr), .host_wdata(host_wdata),
        .host_gnt(host_gnt), .host_ack(host_ack), .host_rdata(host_rdata),
        .mem_addr(mem_addr), .mem_wdata(mem_wdata), .mem_we(mem_we), .mem_rdata(mem_rdata)
    );

    always #5 clk = ~clk;

    // RAM attached to the DUT: async read, write on rising edge
    logic [7:0] ram [256];
    logic [7:0] ref_ram [256];
    logic       ram_load;

    function automatic logic [7:0] init_val(input int i);
        return (i == 130) ? 8'd2 : (8'(i) ^ 8'hA5);
    endfunction

    assign mem_rdata = ram[mem_addr];

    always @(posedge clk) begin
        if (ram_load) begin
            for (int i = 0; i < 256; i++) ram[i] <= init_val(i);
        end else if (mem_we) begin
            ram[mem_addr] <= mem_wdata;
        end
    end

    typedef struct {
        logic       c_req, c_we;
        logic [7:0] c_addr, c_wd;
        logic       h_req, h_we;
        logic [7:0] h_addr, h_wd;
        logic       e_c, e_h;
    } vec_t;

    typedef struct {
        logic       host;
        logic       rd;
        logic [7:0] data;
    } exp_t;

    vec_t       vecs[$];
    exp_t       sb[$];
    int         checks = 0;
    int         errors = 0;
    logic [7:0] exp_crd, exp_hrd;

    function automatic vec_t mk(input logic cr, input logic cw, input logic [7:0] ca, input logic [7:0] cd,
                                input logic hr, input logic hw, input logic [7:0] ha, input logic [7:0] hd,
                                input logic ec, input logic eh);
        vec_t v;
        v.c_req = cr; v.c_we = cw; v.c_addr = ca; v.c_wd = cd;
        v.h_req = hr; v.h_we = hw; v.h_addr = ha; v.h_wd = hd;
        v.e_c = ec; v.e_h = eh;
        return v;
    endfunction

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: actual %0h required %0h", name, act, exp);
        end
    endtask

    task automatic check_zero(input string tag);
        chk({tag, " cpu_gnt"},    32'(cpu_gnt),    0);
        chk({tag, " host_gnt"},   32'(host_gnt),   0);
        chk({tag, " cpu_ack"},    32'(cpu_ack),    0);
        chk({tag, " host_ack"},   32'(host_ack),   0);
        chk({tag, " cpu_rdata"},  32'(cpu_rdata),  0);
        chk({tag, " host_rdata"}, 32'(host_rdata), 0);
        chk({tag, " mem_addr"},   32'(mem_addr),   0);
        chk({tag, " mem_wdata"},  32'(mem_wdata),  0);
        chk({tag, " mem_we"},     32'(mem_we),     0);
    endtask

    task automatic drive(input vec_t v);
        cpu_req  = v.c_req; cpu_we  = v.c_we; cpu_addr  = v.c_addr; cpu_wdata  = v.c_wd;
        host_req = v.h_req; host_we = v.h_we; host_addr = v.h_addr; host_wdata = v.h_wd;
    endtask

    // Called mid-cycle: retires last cycle's expected access, checks this cycle's
    // grants and RAM strobes against the expected owner, then queues this cycle's access.
    task automatic sample_check(input logic e_c, input logic e_h, input string tag);
        exp_t       e;
        logic       ec_ack = 1'b0, eh_ack = 1'b0;
        logic       acc_c, acc_h, e_we;
        logic [7:0] e_addr, e_wd;
        if (sb.size() > 0) begin
            e = sb.pop_front();
            if (e.host) eh_ack = 1'b1; else ec_ack = 1'b1;
            if (e.rd) begin
                if (e.host) exp_hrd = e.data; else exp_crd = e.data;
            end
        end
        chk({tag, " cpu_ack"},    32'(cpu_ack),    32'(ec_ack));
        chk({tag, " host_ack"},   32'(host_ack),   32'(eh_ack));
        chk({tag, " cpu_rdata"},  32'(cpu_rdata),  32'(exp_crd));
        chk({tag, " host_rdata"}, 32'(host_rdata), 32'(exp_hrd));
        chk({tag, " cpu_gnt"},    32'(cpu_gnt),    32'(e_c));
        chk({tag, " host_gnt"},   32'(host_gnt),   32'(e_h));

        acc_c  = e_c & cpu_req;
        acc_h  = e_h & host_req;
        e_we   = acc_c ? cpu_we    : (acc_h ? host_we    : 1'b0);
        e_addr = acc_c ? cpu_addr  : (acc_h ? host_addr  : 8'd0);
        e_wd   = acc_c ? cpu_wdata : (acc_h ? host_wdata : 8'd0);
        chk({tag, " mem_we"},    32'(mem_we),    32'(e_we));
        chk({tag, " mem_addr"},  32'(mem_addr),  32'(e_addr));
        chk({tag, " mem_wdata"}, 32'(mem_wdata), 32'(e_wd));

        if (acc_c || acc_h) begin
            e.host = acc_h;
            e.rd   = !e_we;
            e.data = ref_ram[e_addr];
            sb.push_back(e);
            if (e_we) ref_ram[e_addr] = e_wd;
        end
    endtask

    task automatic restart_scoreboard();
        sb.delete();
        exp_crd = 8'd0;
        exp_hrd = 8'd0;
    endtask

    initial begin
        #100000;
        $display("FAIL timeout: bench did not finish");
        $fatal(1, "timeout");
    end

    initial begin
        // idle / CPU read / host burst / back-to-back reads
        vecs.push_back(mk(0,0,0,0,     0,0,0,0,       0,0));
        vecs.push_back(mk(1,0,130,0,   0,0,0,0,       0,0));
        vecs.push_back(mk(1,0,130,0,   0,0,0,0,       1,0));
        vecs.push_back(mk(0,0,0,0,     0,0,0,0,       1,0));
        vecs.push_back(mk(0,0,0,0,     0,0,0,0,       0,0));
        vecs.push_back(mk(0,0,0,0,     1,1,128,6,     0,0));
        vecs.push_back(mk(0,0,0,0,     1,1,128,6,     0,1));
        vecs.push_back(mk(0,0,0,0,     1,1,129,1,     0,1));
        vecs.push_back(mk(0,0,0,0,     1,1,130,2,     0,1));
        vecs.push_back(mk(0,0,0,0,     0,0,0,0,       0,1));
        vecs.push_back(mk(0,0,0,0,     0,0,0,0,       0,0));
        vecs.push_back(mk(1,0,129,0,   0,0,0,0,       0,0));
        vecs.push_back(mk(1,0,129,0,   0,0,0,0,       1,0));
        vecs.push_back(mk(1,0,128,0,   0,0,0,0,       1,0));
        vecs.push_back(mk(0,0,0,0,     0,0,0,0,       1,0));
        vecs.push_back(mk(0,0,0,0,     0,0,0,0,       0,0));
        // CPU drops after two accesses while host waits; host run counts from zero
        vecs.push_back(mk(1,0,10,0,    0,0,0,0,       0,0));
        vecs.push_back(mk(1,0,11,0,    1,1,20,8'h77,  1,0));
        vecs.push_back(mk(1,0,12,0,    1,1,20,8'h77,  1,0));
        vecs.push_back(mk(0,0,0,0,     1,1,20,8'h77,  1,0));
        vecs.push_back(mk(0,0,0,0,     1,1,20,8'h77,  0,0));
        vecs.push_back(mk(0,0,0,0,     1,1,20,8'h77,  0,1));
        vecs.push_back(mk(1,0,5,0,     1,1,21,8'h78,  0,1));
        vecs.push_back(mk(1,0,5,0,     1,1,22,8'h79,  0,1));
        vecs.push_back(mk(1,0,5,0,     1,1,23,8'h7A,  0,1));
        vecs.push_back(mk(1,0,5,0,     1,1,24,8'h7B,  0,0));
        vecs.push_back(mk(1,0,5,0,     1,1,24,8'h7B,  1,0));
        vecs.push_back(mk(0,0,0,0,     1,1,24,8'h7B,  1,0));
        vecs.push_back(mk(0,0,0,0,     1,1,24,8'h7B,  0,0));
        vecs.push_back(mk(0,0,0,0,     0,0,0,0,       0,1));
        vecs.push_back(mk(0,0,0,0,     0,0,0,0,       0,0));
        // lone CPU run saturates, then yields on the next access once host requests
        vecs.push_back(mk(1,0,40,0,    0,0,0,0,       0,0));
        for (int k = 0; k < 6; k++)
            vecs.push_back(mk(1,0,8'(40 + k),0, 0,0,0,0, 1,0));
        vecs.push_back(mk(1,0,50,0,    1,1,60,8'h33,  1,0));
        vecs.push_back(mk(1,0,50,0,    1,1,60,8'h33,  0,0));
        vecs.push_back(mk(1,0,50,0,    1,1,60,8'h33,  0,1));
        vecs.push_back(mk(1,0,50,0,    0,0,0,0,       0,1));
        vecs.push_back(mk(1,0,60,0,    0,0,0,0,       0,0));
        vecs.push_back(mk(1,0,60,0,    0,0,0,0,       1,0));
        vecs.push_back(mk(0,0,0,0,     0,0,0,0,       1,0));
        vecs.push_back(mk(0,0,0,0,     0,0,0,0,       0,0));

        for (int i = 0; i < 256; i++) ref_ram[i] = init_val(i);

        rst = 1'b0;
        ram_load = 1'b1;
        drive(mk(0,0,0,0, 0,0,0,0, 0,0));
        #2;
        check_zero("reset0");
        @(posedge clk); #1;
        ram_load = 1'b0;
        @(posedge clk); #1;
        rst = 1'b1;
        restart_scoreboard();

        foreach (vecs[i]) begin
            drive(vecs[i]);
            @(negedge clk);
            sample_check(vecs[i].e_c, vecs[i].e_h, $sformatf("v%0d", i));
            @(posedge clk); #1;
        end

        // Contention from reset release: 4 CPU, IDLE, 4 host, IDLE, ...
        rst = 1'b0;
        #1;
        check_zero("reset1");
        restart_scoreboard();
        cpu_req = 1'b1; cpu_we = 1'b0; host_req = 1'b1; host_we = 1'b0;
        @(posedge clk); #1;
        rst = 1'b1;
        for (int k = 0; k < 30; k++) begin
            cpu_addr  = 8'(k);
            host_addr = 8'(255 - k);
            @(negedge clk);
            sample_check((k % 10 >= 1) && (k % 10 <= 4), (k % 10 >= 6), $sformatf("cont%0d", k));
            @(posedge clk); #1;
        end

        // Reset in the middle of a host write
        rst = 1'b0;
        drive(mk(0,0,0,0, 0,0,0,0, 0,0));
        #1;
        check_zero("reset2");
        restart_scoreboard();
        @(posedge clk); #1;
        rst = 1'b1;
        drive(mk(0,0,0,0, 1,1,200,8'hEE, 0,0));
        @(negedge clk);
        sample_check(1'b0, 1'b0, "abort_idle");
        @(posedge clk); #2;
        chk("abort pre host_gnt", 32'(host_gnt), 1);
        chk("abort pre mem_we",   32'(mem_we),   1);
        rst = 1'b0;
        #1;
        check_zero("abort");
        @(posedge clk); #1;
        chk("abort host_ack", 32'(host_ack), 0);
        chk("abort ram200",   32'(ram[200]), 32'(ref_ram[200]));
        drive(mk(1,0,1,0, 1,1,200,8'hEE, 0,0));
        rst = 1'b1;
        restart_scoreboard();
        @(negedge clk);
        sample_check(1'b0, 1'b0, "rel_idle");
        @(posedge clk); #1;
        @(negedge clk);
        sample_check(1'b1, 1'b0, "rel_cpu_first");
        @(posedge clk); #1;
        drive(mk(0,0,0,0, 0,0,0,0, 0,0));
        @(negedge clk);
        sample_check(1'b1, 1'b0, "rel_cpu_drop");

        chk("ram128", 32'(ram[128]), 6);
        chk("ram129", 32'(ram[129]), 1);
        chk("ram130", 32'(ram[130]), 2);
        chk("ram60",  32'(ram[60]),  32'h33);
        chk("ram23",  32'(ram[23]),  32'h7A);
        begin
            int diffs = 0;
            for (int i = 0; i < 256; i++) if (ram[i] !== ref_ram[i]) diffs++;
            chk("ram image diffs", 32'(diffs), 0);
        end

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule

// File: doc/ram_arbiter.md
RAM_ARBITER -- requirements
Module: ram_arbiter

Interface
REQ-001 Parameter: MAX_RUN, 4, maximum consecutive accesses by one owner while the other side is requesting (range 1..7).
REQ-002 clk  input  1  single clock; all state changes on rising edge.
REQ-003 rst  input  1  reset, asynchronous, active-low.
REQ-004 cpu_req  input  1  CPU access request, level, held until served.
REQ-005 cpu_we  input  1  CPU write enable (1 = write, 0 = read).
REQ-006 cpu_addr  input  8  CPU word address.
REQ-007 cpu_wdata  input  8  CPU write data.
REQ-008 cpu_gnt  output  1  CPU owns the RAM port this cycle.
REQ-009 cpu_ack  output  1  one-cycle pulse: one CPU access completed in the previous cycle.
REQ-010 cpu_rdata  output  8  registered CPU read data.
REQ-011 host_req, host_we, host_addr[8], host_wdata[8]  input  same meanings for the host/loader port.
REQ-012 host_gnt, host_ack, host_rdata[8]  output  same meanings for the host/loader port.
REQ-013 mem_addr  output  8  RAM address.
REQ-014 mem_wdata  output  8  RAM write data.
REQ-015 mem_we  output  1  RAM write strobe; the RAM writes on the rising edge while it is high.
REQ-016 mem_rdata  input  8  RAM read data; asynchronous read of mem_addr.

Function
REQ-017 FSM states: IDLE, CPU_OWN, HOST_OWN. cpu_gnt = (state==CPU_OWN). host_gnt = (state==HOST_OWN). Both grants are decoded from registers and are never high together.
REQ-018 IDLE: mem_we=0, mem_addr=0, mem_wdata=0. No access occurs.
REQ-019 IDLE transitions:
- Only one side requesting: go to that side's OWN state.
- Both requesting: grant the side that is not last_owner.
- Neither requesting: stay in IDLE.
REQ-020 Arbitration latency: a request first seen in IDLE yields its grant on the next cycle.
REQ-021 An access occurs on any cycle where the owner's grant and req are both high. During that cycle the owner's addr, we and wdata drive the mem_* outputs combinationally. The non-owner's inputs are ignored.
REQ-022 In an OWN state with the owner's req low: mem_we=0 and the next state is IDLE.
REQ-023 run_cnt (3 bits) counts accesses in the current ownership.
- It is cleared on entry to IDLE.
- When an access makes run_cnt reach MAX_RUN while the other side's req is high, the next state is IDLE.
- When it reaches MAX_RUN with the other side idle, ownership continues and run_cnt saturates at MAX_RUN.
REQ-024 last_owner is updated to the owner whenever an OWN state exits to IDLE.
REQ-025 Every transition between owners passes through exactly one IDLE cycle.
REQ-026 Acknowledge timing:
- x_ack is registered and equals (x_gnt & x_req) of the previous cycle.
- On a read access, x_rdata loads mem_rdata at the same edge.
- x_rdata holds its value otherwise, including on writes.
REQ-027 Owner req and address may change on every cycle. Back-to-back accesses give one ack per cycle.

Reset
REQ-028 While rst=0: state=IDLE, run_cnt=0, last_owner=HOST (the CPU wins the first tie).
REQ-029 While rst=0, all outputs are 0: cpu_gnt, host_gnt, cpu_ack, host_ack, cpu_rdata, host_rdata, mem_addr, mem_wdata, mem_we.
REQ-030 Reset asserted mid-access forces mem_we=0 immediately, without waiting for a clock edge. The interrupted access produces no ack.
REQ-031 After rst rises, arbitration starts from IDLE on the first rising edge.

Verification
REQ-032 Reset: rst=0 at an arbitrary time -> all outputs 0 asynchronously; after release with no requests, the FSM stays in IDLE.
REQ-033 CPU read, RAM[130]=2: cpu_req=1, cpu_we=0, cpu_addr=130 at cycle 0 -> cpu_gnt=1 and mem_addr=130 at cycle 1; cpu_ack=1 and cpu_rdata=2 at cycle 2.
REQ-034 Host burst writes 128/129/130 <- 6/1/2, CPU idle -> host_gnt from cycle 1; mem_we high for cycles 1-3; host_ack for cycles 2-4; RAM then holds 6, 1, 2.
REQ-035 Contention, MAX_RUN=4: both req held from reset release -> 4 CPU accesses, 1 IDLE, 4 host accesses, 1 IDLE, then repeating; never any grant overlap.
REQ-036 cpu_req drops after 2 accesses while host_req=1 -> IDLE next cycle, then host_gnt; host run_cnt starts at 0.
REQ-037 rst=0 in the middle of a host write cycle -> mem_we and host_gnt fall immediately, no host_ack, addressed RAM word unchanged; after release with both req high, the CPU is granted first.
